inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch-side producer for the main control decoder: owns the PC, fetches words from
//  instruction memory over a req/ack handshake, and presents inst + control_on (valid)
//  to the decode stage. Applies PC redirects from branch/jal resolution and discards
//  stale fetches. Sits between imem and the control/decode logic of the core.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk             in   1     single clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  fetch_en        in   1     enables issuing new fetches
//  imem_req        out  1     fetch request, held until imem_ack
//  imem_addr       out  XLEN  fetch address (= pc), stable while imem_req
//  imem_ack        in   1     imem has valid data on imem_rdata this cycle
//  imem_rdata      in   XLEN  fetched instruction word
//  inst            out  XLEN  instruction to decoder (inst[6:0] opcode, inst[7] etc.)
//  pc              out  XLEN  address of inst
//  control_on      out  1     inst valid; decoder outputs meaningful only when high
//  inst_ready      in   1     decode stage consumes inst this cycle
//  redirect_valid  in   1     taken branch / jal: restart fetch at redirect_pc
//  redirect_pc     in   XLEN  redirect target
//  misalign_err    out  1     1-cycle pulse: redirect_pc[1:0]!=0 (bits forced to 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, control_on=0,
//   inst=32'h0000_0013 (nop), misalign_err=0, kill=0. Outputs all registered.
//  FSM IDLE -> REQ -> HOLD:
//   IDLE: fetch_en=1 -> imem_req=1, imem_addr=pc next cycle, go REQ.
//   REQ : imem_req held, addr stable. On imem_ack: if kill=0 latch imem_rdata->inst,
//         control_on=1 next cycle, go HOLD; if kill=1 drop data, clear kill, reissue
//         at new pc (stay REQ, imem_req deasserts one cycle between requests).
//   HOLD: control_on=1, inst/pc stable until inst_ready=1. On consume: pc<=pc+4
//         (wraps mod 2^XLEN), control_on=0; fetch_en=1 -> REQ next cycle, else IDLE.
//  Latency: fetch_en rise to control_on >= 2 cycles (ack in first req cycle);
//   max throughput 1 inst / 3 cycles with zero-wait imem.
//  Redirect (priority over everything except reset):
//   - pc<=redirect_pc & ~3; misalign_err pulses if redirect_pc[1:0]!=0.
//   - HOLD: held inst dropped, control_on=0 next cycle, go REQ (if fetch_en) or IDLE.
//   - HOLD with inst_ready in same cycle: redirect wins; pc=redirect target, not +4.
//   - REQ without ack this cycle: set kill; outstanding req completes then discarded.
//   - REQ with ack this cycle: data discarded, reissue at target.
//   - IDLE: pc updated only.
//  fetch_en low during REQ: request not abandoned; inst presented, then IDLE.
//  Back-to-back redirects: last one wins; kill stays set until the one ack arrives.
//  control_on never high for an instruction fetched before the latest redirect.
// STRUCTURE
//  Shared package: fetch state enum {IDLE,REQ,HOLD}, NOP_INST=32'h0000_0013,
//   default RESET_PC, INST_BYTES=4.
//  One sub-module: fetch_pc_next (comb next-PC mux: hold / +4 / redirect&~3, misalign flag).
// TESTING
//  Reset mid-REQ: rst_n low while imem_req=1 -> next cycle imem_req=0, pc=RESET_PC, control_on=0.
//  Sequential: zero-wait ack, inst_ready=1 -> addrs 0x0,0x4,0x8; control_on every 3rd cycle.
//  Stall: inst_ready=0 for 5 cycles in HOLD -> inst/pc stable, no new imem_req.
//  Kill: redirect_pc=0x100 in REQ, ack 3 cycles later with 0x00000063 -> dropped; next addr 0x100.
//  Redirect+consume same cycle in HOLD at pc=0x8 -> next fetch 0x40 (redirect_pc), not 0xC.
//  Misaligned: redirect_pc=0x102 -> misalign_err 1-cycle pulse, fetch at 0x100; pc 0xFFFF_FFFC +4 -> 0x0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared fetch states and constants for the instruction fetch unit
package inst_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam logic [1:0]  ST_IDLE      = IDLE;
   localparam logic [1:0]  ST_REQ       = REQ;
   localparam logic [1:0]  ST_HOLD      = HOLD;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          INST_BYTES   = 4;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - next-PC mux: hold, sequential advance, or word-aligned redirect
module fetch_pc_next #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_q,
   input  logic            advance,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_d,
   output logic            misalign
);
   import inst_fetch_unit_pkg::*;

   always_comb begin
      pc_d     = pc_q;
      misalign = 1'b0;
      // Redirect outranks a same-cycle consume, so the +4 is never taken then
      if (redirect_valid) begin
         pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
         misalign = |redirect_pc[1:0];
      end else if (advance) begin
         pc_d = pc_q + XLEN'(INST_BYTES);
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and imem req/ack fetcher feeding the control decoder
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_en,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic            control_on,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign_err
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] imem_addr_q, imem_addr_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            imem_req_q, imem_req_d;
   logic            control_on_q, control_on_d;
   logic            kill_q, kill_d;
   logic            misalign_err_q, misalign_err_d;
   logic            advance;

   assign advance = (state_q == ST_HOLD) && inst_ready;

   fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
      .pc_q           (pc_q),
      .advance        (advance),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_d           (pc_d),
      .misalign       (misalign_err_d)
   );

   always_comb begin
      state_d      = state_q;
      imem_req_d   = imem_req_q;
      imem_addr_d  = imem_addr_q;
      inst_d       = inst_q;
      control_on_d = control_on_q;
      kill_d       = kill_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_en) begin
               state_d    = ST_REQ;
               imem_req_d = 1'b1;
            end
         end
         ST_REQ: begin
            // REQ with imem_req low is the one-cycle gap before (re)issuing
            if (!imem_req_q) begin
               imem_req_d = 1'b1;
            end else if (imem_ack) begin
               imem_req_d = 1'b0;
               if (kill_q || redirect_valid) begin
                  kill_d = 1'b0;
               end else begin
                  inst_d       = imem_rdata;
                  control_on_d = 1'b1;
                  state_d      = ST_HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid || inst_ready) begin
               control_on_d = 1'b0;
               state_d      = fetch_en ? ST_REQ : ST_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            imem_req_d   = 1'b0;
            control_on_d = 1'b0;
            kill_d       = 1'b0;
         end
      endcase
      // Address is captured only at issue so it stays stable while a killed request drains
      if (imem_req_d && !imem_req_q) begin
         imem_addr_d = pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         pc_q           <= RESET_PC;
         imem_addr_q    <= RESET_PC;
         inst_q         <= XLEN'(NOP_INST);
         imem_req_q     <= 1'b0;
         control_on_q   <= 1'b0;
         kill_q         <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         imem_addr_q    <= imem_addr_d;
         inst_q         <= inst_d;
         imem_req_q     <= imem_req_d;
         control_on_q   <= control_on_d;
         kill_q         <= kill_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = imem_addr_q;
   assign inst         = inst_q;
   assign pc           = pc_q;
   assign control_on   = control_on_q;
   assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit with a latency-programmable imem model
module tb_inst_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_t;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        control_on;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   int          checks;
   int          failures;
   int          ack_delay;
   int          req_age;
   logic [31:0] ovr_addr;
   logic [31:0] ovr_data;
   logic        prev_req;
   fetch_t      exp_q[$];
   fetch_t      obs_q[$];
   logic [31:0] issue_q[$];

   inst_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst           (inst),
      .pc             (pc),
      .control_on     (control_on),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == ovr_addr) ? ovr_data : ((a ^ 32'h1357_9BDF) + 32'h0000_0100);
   endfunction

   // imem model: acks after ack_delay request cycles
   always @(negedge clk) begin
      if (!rst_n || !imem_req || imem_ack) begin
         imem_ack = 1'b0;
         req_age  = 0;
      end else if (req_age >= ack_delay) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         req_age++;
      end
   end

   // monitor: records issued addresses and consumed instructions
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (imem_req && !prev_req) issue_q.push_back(imem_addr);
         if (control_on && inst_ready && !redirect_valid) obs_q.push_back({pc, inst});
         prev_req = imem_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit got;
      rst_n = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 00000000", pc); end
      checks++; if (control_on !== 1'b0) begin failures++; $display("FAIL rst_con: got %b want 0", control_on); end
      checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst: got %h want 00000013", inst); end
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_mis: got %b want 0", misalign_err); end
      rst_n = 1'b1;
      tick();
      ack_delay = 20; fetch_en = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (imem_req) got = 1'b1;
      end
      checks++; if (!got) begin failures++; $display("FAIL rst_midreq_wait: got no imem_req want one within 10 cycles"); end
      rst_n = 1'b0; fetch_en = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midreq_req: got %b want 0", imem_req); end
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midreq_pc: got %h want 00000000", pc); end
      checks++; if (control_on !== 1'b0) begin failures++; $display("FAIL midreq_con: got %b want 0", control_on); end
      rst_n = 1'b1; ack_delay = 0;
      repeat (2) tick();
   endtask

   task automatic test_sequential();
      int ob, ib, n;
      int cyc[3];
      fetch_t e, o;
      logic [31:0] want_addr[3];
      want_addr = '{32'h0, 32'h4, 32'h8};
      ob = obs_q.size(); ib = issue_q.size(); n = 0;
      for (int k = 0; k < 3; k++) exp_q.push_back({want_addr[k], mem_word(want_addr[k])});
      ack_delay = 0; fetch_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (control_on) begin
            cyc[n] = i; n++;
            if (n == 3) begin fetch_en = 1'b0; break; end
         end
      end
      repeat (3) tick();
      checks++; if (n != 3) begin failures++; $display("FAIL seq_count: got %0d want 3 valid cycles", n); end
      checks++; if (n == 3 && cyc[1] - cyc[0] != 3) begin failures++; $display("FAIL seq_gap0: got %0d want 3", cyc[1] - cyc[0]); end
      checks++; if (n == 3 && cyc[2] - cyc[1] != 3) begin failures++; $display("FAIL seq_gap1: got %0d want 3", cyc[2] - cyc[1]); end
      checks++; if (imem_req !== 1'b0 || pc !== 32'hC) begin failures++; $display("FAIL seq_idle: got req %b pc %h want req 0 pc 0000000c", imem_req, pc); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ib + k >= issue_q.size() || issue_q[ib + k] !== want_addr[k]) begin
            failures++; $display("FAIL seq_addr[%0d]: got %h want %h", k, (ib + k < issue_q.size()) ? issue_q[ib + k] : 32'hx, want_addr[k]);
         end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (ob < obs_q.size()) ? obs_q[ob] : '0;
         ob++;
         checks++; if (o !== e) begin failures++; $display("FAIL seq_fetch: got pc_inst %h want %h", o, e); end
      end
   endtask

   task automatic test_stall();
      int ob;
      bit got;
      fetch_t e, o;
      ob = obs_q.size();
      exp_q.push_back({32'hC, mem_word(32'hC)});
      ack_delay = 0; fetch_en = 1'b1; inst_ready = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (control_on) got = 1'b1;
      end
      checks++; if (!got) begin failures++; $display("FAIL stall_wait: got no control_on want one within 10 cycles"); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (control_on !== 1'b1 || pc !== 32'hC || inst !== mem_word(32'hC) || imem_req !== 1'b0) begin
            failures++; $display("FAIL stall_hold[%0d]: got con %b pc %h inst %h req %b want 1 0000000c %h 0", i, control_on, pc, inst, imem_req, mem_word(32'hC));
         end
      end
      inst_ready = 1'b1; fetch_en = 1'b0;
      tick();
      inst_ready = 1'b0;
      tick();
      checks++; if (pc !== 32'h10 || control_on !== 1'b0) begin failures++; $display("FAIL stall_after: got pc %h con %b want 00000010 0", pc, control_on); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (ob < obs_q.size()) ? obs_q[ob] : '0;
         ob++;
         checks++; if (o !== e) begin failures++; $display("FAIL stall_fetch: got pc_inst %h want %h", o, e); end
      end
      checks++; if (obs_q.size() != ob) begin failures++; $display("FAIL stall_extra: got %0d consumes want %0d", obs_q.size(), ob); end
   endtask

   task automatic test_kill();
      int ob, ib;
      bit got;
      fetch_t e, o;
      ob = obs_q.size(); ib = issue_q.size();
      exp_q.push_back({32'h100, mem_word(32'h100)});
      ovr_addr = 32'h10; ovr_data = 32'h0000_0063;
      ack_delay = 3; fetch_en = 1'b1; inst_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (imem_req) got = 1'b1;
      end
      checks++; if (!got || imem_addr !== 32'h10) begin failures++; $display("FAIL kill_issue: got req %b addr %h want 1 00000010", got, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL kill_stable: got req %b addr %h want 1 00000010", imem_req, imem_addr); end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (control_on) begin got = 1'b1; fetch_en = 1'b0; end
      end
      checks++; if (!got) begin failures++; $display("FAIL kill_wait: got no control_on want one within 40 cycles"); end
      repeat (2) tick();
      checks++; if (pc !== 32'h104) begin failures++; $display("FAIL kill_pc: got %h want 00000104", pc); end
      checks++;
      if (issue_q.size() != ib + 2 || issue_q[ib] !== 32'h10 || issue_q[ib + 1] !== 32'h100) begin
         failures++; $display("FAIL kill_addrs: got %0d issues last %h want 2 issues 00000010 00000100", issue_q.size() - ib, issue_q[issue_q.size() - 1]);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (ob < obs_q.size()) ? obs_q[ob] : '0;
         ob++;
         checks++; if (o !== e) begin failures++; $display("FAIL kill_fetch: got pc_inst %h want %h", o, e); end
      end
      checks++; if (obs_q.size() != ob) begin failures++; $display("FAIL kill_extra: got %0d consumes want %0d", obs_q.size(), ob); end
      ovr_addr = 32'h1; ack_delay = 0;
   endtask

   task automatic test_redirect_consume();
      int ob, ib;
      bit got;
      fetch_t e, o;
      ob = obs_q.size(); ib = issue_q.size();
      exp_q.push_back({32'h40, mem_word(32'h40)});
      fetch_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc !== 32'h8 || imem_req !== 1'b0) begin failures++; $display("FAIL rc_idle: got pc %h req %b want 00000008 0", pc, imem_req); end
      fetch_en = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (control_on) got = 1'b1;
      end
      checks++; if (!got || pc !== 32'h8) begin failures++; $display("FAIL rc_hold: got con %b pc %h want 1 00000008", got, pc); end
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc !== 32'h40 || control_on !== 1'b0) begin failures++; $display("FAIL rc_pc: got pc %h con %b want 00000040 0", pc, control_on); end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (control_on) begin got = 1'b1; fetch_en = 1'b0; end
      end
      repeat (2) tick();
      checks++;
      if (issue_q.size() != ib + 2 || issue_q[ib] !== 32'h8 || issue_q[ib + 1] !== 32'h40) begin
         failures++; $display("FAIL rc_addrs: got %0d issues last %h want 2 issues 00000008 00000040", issue_q.size() - ib, issue_q[issue_q.size() - 1]);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (ob < obs_q.size()) ? obs_q[ob] : '0;
         ob++;
         checks++; if (o !== e) begin failures++; $display("FAIL rc_fetch: got pc_inst %h want %h", o, e); end
      end
      checks++; if (obs_q.size() != ob) begin failures++; $display("FAIL rc_extra: got %0d consumes want %0d", obs_q.size(), ob); end
   endtask

   task automatic test_misalign_wrap();
      int ob, ib, n;
      fetch_t e, o;
      ob = obs_q.size(); ib = issue_q.size();
      exp_q.push_back({32'h100, mem_word(32'h100)});
      exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
      exp_q.push_back({32'h0, mem_word(32'h0)});
      fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      checks++; if (misalign_err !== 1'b1 || pc !== 32'h100) begin failures++; $display("FAIL mis_pulse: got err %b pc %h want 1 00000100", misalign_err, pc); end
      tick();
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_width: got %b want 0", misalign_err); end
      n = 0;
      for (int i = 0; i < 10 && n == 0; i++) begin
         if (control_on) begin n = 1; fetch_en = 1'b0; end
         else tick();
      end
      repeat (2) tick();
      fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      checks++; if (misalign_err !== 1'b0 || pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_redir: got err %b pc %h want 0 fffffffc", misalign_err, pc); end
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         tick();
         if (control_on) begin n++; if (n == 2) fetch_en = 1'b0; end
      end
      repeat (2) tick();
      checks++; if (pc !== 32'h4) begin failures++; $display("FAIL wrap_pc: got %h want 00000004", pc); end
      checks++;
      if (issue_q.size() != ib + 3 || issue_q[ib] !== 32'h100 || issue_q[ib + 1] !== 32'hFFFF_FFFC || issue_q[ib + 2] !== 32'h0) begin
         failures++; $display("FAIL wrap_addrs: got %0d issues last %h want 3 issues 00000100 fffffffc 00000000", issue_q.size() - ib, issue_q[issue_q.size() - 1]);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (ob < obs_q.size()) ? obs_q[ob] : '0;
         ob++;
         checks++; if (o !== e) begin failures++; $display("FAIL wrap_fetch: got pc_inst %h want %h", o, e); end
      end
   endtask

   initial begin
      checks = 0; failures = 0; ack_delay = 0;
      ovr_addr = 32'h1; ovr_data = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_kill();
      test_redirect_consume();
      test_misalign_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
